// File: rtl/sram_burst_ctrl.sv
// rtl/sram_burst_ctrl.sv - DDR-style wrapping burst requester for a single-port block RAM
// One read or write burst of BL beats per command; read data returns through a 3-stage pipeline.
module sram_burst_ctrl #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 2048,
  parameter int  BL    = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [AW-1:0]    cmd_addr,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             done,
  output logic [AW-1:0]    sram_addr,
  output logic             sram_rd_o_wr,
  output logic [WIDTH-1:0] sram_i_data,
  input  logic [WIDTH-1:0] sram_o_data
);

  localparam int LBL = $clog2(BL);
  localparam logic [AW-1:0]  WRAP_MASK = AW'(BL - 1);
  localparam logic [LBL-1:0] LAST_BEAT = LBL'(BL - 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN} state_t;

  state_t           state_q;
  logic [AW-1:0]    base_q;
  logic [LBL-1:0]   beat_q;
  logic [AW-1:0]    beat_addr_d;
  logic             p1_q, p1_last_q, p2_q, p2_last_q;
  logic             rd_valid_q, done_q, sram_we_q;
  logic [WIDTH-1:0] rd_data_q, sram_wdata_q;
  logic [AW-1:0]    sram_addr_q;

  // Block bits come from the base, low bits wrap within the BL-aligned block.
  assign beat_addr_d = (base_q & ~WRAP_MASK) | ((base_q + AW'(beat_q)) & WRAP_MASK);

  assign cmd_ready    = (state_q == S_IDLE);
  assign wr_ready     = (state_q == S_WRITE);
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign done         = done_q;
  assign sram_addr    = sram_addr_q;
  assign sram_rd_o_wr = sram_we_q;
  assign sram_i_data  = sram_wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      beat_q       <= '0;
      p1_q         <= 1'b0;
      p1_last_q    <= 1'b0;
      p2_q         <= 1'b0;
      p2_last_q    <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      done_q       <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
    end else begin
      sram_we_q  <= 1'b0;
      p1_q       <= 1'b0;
      p1_last_q  <= 1'b0;
      p2_q       <= p1_q;
      p2_last_q  <= p1_last_q;
      rd_valid_q <= p2_q;
      done_q     <= p2_last_q;
      if (p2_q) begin
        rd_data_q <= sram_o_data;
      end
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            base_q <= cmd_addr;
            if (cmd_we) begin
              beat_q  <= '0;
              state_q <= S_WRITE;
            end else begin
              // Beat 0 is issued on the accept edge so its address is out one cycle later.
              sram_addr_q <= cmd_addr;
              p1_q        <= 1'b1;
              beat_q      <= LBL'(1);
              state_q     <= S_READ;
            end
          end
        end
        S_WRITE: begin
          if (wr_valid) begin
            sram_addr_q  <= beat_addr_d;
            sram_wdata_q <= wr_data;
            sram_we_q    <= 1'b1;
            beat_q       <= beat_q + LBL'(1);
            if (beat_q == LAST_BEAT) begin
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end
          end
        end
        S_READ: begin
          sram_addr_q <= beat_addr_d;
          p1_q        <= 1'b1;
          beat_q      <= beat_q + LBL'(1);
          if (beat_q == LAST_BEAT) begin
            p1_last_q <= 1'b1;
            state_q   <= S_DRAIN;
          end
        end
        default: begin
          // done_q is high in the last rd_valid cycle; leave DRAIN right after it.
          if (done_q) begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
